// File: rtl/led_sched_pkg.sv
// rtl/led_sched_pkg.sv - shared types and constants for the LED slot scheduler
package led_sched_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SCAN,
        ST_DRIVE,
        ST_BLANK
    } state_t;

    localparam int CODE_W_DEF = 10;
    localparam int BLANK_CODE = 0;
    localparam int X_MSB      = 2;
    localparam int MAX_LEN    = 3;

    // A run that walks past the last column is blanked rather than carried into the row bits
    function automatic logic col_overflow(input logic [X_MSB:0] col, input logic [1:0] off);
        return (int'(col) + int'(off)) > (2 ** (X_MSB + 1) - 1);
    endfunction

endpackage

// File: rtl/led_rr_pick.sv
// rtl/led_rr_pick.sv - combinational circular priority finder starting after ptr
module led_rr_pick #(
    parameter int N  = 4,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  valid,
    input  logic [IW-1:0] ptr,
    output logic          found,
    output logic [IW-1:0] index
);

    logic [IW-1:0] cand;

    always_comb begin
        found = 1'b0;
        index = '0;
        cand  = '0;
        for (int i = 1; i <= N; i++) begin
            cand = IW'((int'(ptr) + i) % N);
            if (!found && valid[cand]) begin
                found = 1'b1;
                index = cand;
            end
        end
    end

endmodule

// File: rtl/led_slot_scheduler.sv
// rtl/led_slot_scheduler.sv - round-robin time-division driver of the LED code word
// Optional BLANK gap between slots enabled by defining LED_SCHED_BLANK_EN.
module led_slot_scheduler
    import led_sched_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int DWELL   = 2001,
    parameter int CODE_W  = CODE_W_DEF
) (
    input  logic                  CLK,
    input  logic                  RSTn,
    input  logic                  EN,
    input  logic [NUM_REQ-1:0]    REQ_VALID,
    input  logic [NUM_REQ*CODE_W-1:0] REQ_CODE,
    input  logic [NUM_REQ*2-1:0]  REQ_LEN,
    output logic [CODE_W-1:0]     LEDout,
    output logic [NUM_REQ-1:0]    GRANT,
    output logic                  FRAME_DONE
);

    localparam int PW = $clog2(NUM_REQ);
    localparam int DW = $clog2(DWELL);

    state_t             state;
    logic [PW-1:0]      ptr;
    logic [DW-1:0]      dwell;
    logic [1:0]         offset;
    logic [CODE_W-1:0]  lat_code;
    logic [1:0]         lat_len;

    logic               pick_found;
    logic [PW-1:0]      pick_idx;
    logic [CODE_W-1:0]  pick_code;
    logic [1:0]         pick_len_raw;
    logic [1:0]         pick_len;
    logic               dwell_end;
    logic               last_pixel;

    function automatic logic [CODE_W-1:0] pixel(input logic [CODE_W-1:0] code, input logic [1:0] off);
        if (col_overflow(code[X_MSB:0], off))
            return CODE_W'(BLANK_CODE);
        return code + {{(CODE_W-2){1'b0}}, off};
    endfunction

    led_rr_pick #(.N(NUM_REQ), .IW(PW)) u_pick (
        .valid (REQ_VALID),
        .ptr   (ptr),
        .found (pick_found),
        .index (pick_idx)
    );

    assign pick_code    = REQ_CODE[pick_idx*CODE_W +: CODE_W];
    assign pick_len_raw = REQ_LEN[pick_idx*2 +: 2];
    assign pick_len     = (pick_len_raw == 2'd0) ? 2'd1 : pick_len_raw;
    assign dwell_end    = (dwell == DW'(DWELL - 1));
    assign last_pixel   = (offset == lat_len - 2'd1);

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state      <= ST_IDLE;
            ptr        <= PW'(NUM_REQ - 1);
            dwell      <= '0;
            offset     <= '0;
            lat_code   <= '0;
            lat_len    <= 2'd1;
            LEDout     <= '0;
            GRANT      <= '0;
            FRAME_DONE <= 1'b0;
        end else begin
            FRAME_DONE <= 1'b0;
            if (!EN) begin
                // ptr is kept so a resume continues the rotation
                state  <= ST_IDLE;
                LEDout <= '0;
                GRANT  <= '0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        LEDout <= '0;
                        GRANT  <= '0;
                        state  <= ST_SCAN;
                    end
                    ST_SCAN: begin
                        if (pick_found) begin
                            lat_code   <= pick_code;
                            lat_len    <= pick_len;
                            ptr        <= pick_idx;
                            offset     <= '0;
                            dwell      <= '0;
                            GRANT      <= NUM_REQ'(1) << pick_idx;
                            LEDout     <= pixel(pick_code, 2'd0);
                            FRAME_DONE <= (pick_idx <= ptr);
                            state      <= ST_DRIVE;
                        end else begin
                            LEDout <= '0;
                            GRANT  <= '0;
                        end
                    end
                    ST_DRIVE: begin
                        // Outputs hold on abort until the next pick replaces them
                        if (!REQ_VALID[ptr]) begin
                            state <= ST_SCAN;
                        end else if (!dwell_end) begin
                            dwell <= dwell + DW'(1);
                        end else if (!last_pixel) begin
                            offset <= offset + 2'd1;
                            dwell  <= '0;
                            LEDout <= pixel(lat_code, offset + 2'd1);
                        end else begin
`ifdef LED_SCHED_BLANK_EN
                            state  <= ST_BLANK;
                            LEDout <= '0;
                            GRANT  <= '0;
                            dwell  <= '0;
`else
                            state  <= ST_SCAN;
`endif
                        end
                    end
`ifdef LED_SCHED_BLANK_EN
                    ST_BLANK: begin
                        if (dwell_end)
                            state <= ST_SCAN;
                        else
                            dwell <= dwell + DW'(1);
                    end
`endif
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_led_slot_scheduler.sv
// tb/tb_led_slot_scheduler.sv - randomized and directed checks against a slot-trace model
module tb_led_slot_scheduler;

    localparam int NUM_REQ = 4;
    localparam int DWELL   = 4;
    localparam int CODE_W  = 10;

    logic                      CLK = 1'b0;
    logic                      RSTn;
    logic                      EN;
    logic [NUM_REQ-1:0]        REQ_VALID;
    logic [NUM_REQ*CODE_W-1:0] REQ_CODE;
    logic [NUM_REQ*2-1:0]      REQ_LEN;
    logic [CODE_W-1:0]         LEDout;
    logic [NUM_REQ-1:0]        GRANT;
    logic                      FRAME_DONE;

    led_slot_scheduler #(.NUM_REQ(NUM_REQ), .DWELL(DWELL), .CODE_W(CODE_W)) dut (
        .CLK        (CLK),
        .RSTn       (RSTn),
        .EN         (EN),
        .REQ_VALID  (REQ_VALID),
        .REQ_CODE   (REQ_CODE),
        .REQ_LEN    (REQ_LEN),
        .LEDout     (LEDout),
        .GRANT      (GRANT),
        .FRAME_DONE (FRAME_DONE)
    );

    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_pass   = 0;
    int mptr;
    int q_led[$];
    int q_gnt[$];
    int q_fd[$];

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got == exp)
            n_pass++;
        else
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic check_out(input string tag, input int led, input int gnt, input int fd);
        check({tag, ".led"},   int'(LEDout),     led);
        check({tag, ".grant"}, int'(GRANT),      gnt);
        check({tag, ".frame"}, int'(FRAME_DONE), fd);
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    function automatic int pix(input int code, input int off);
        if ((code & 7) + off > 7)
            return 0;
        return (code + off) & 'h3FF;
    endfunction

    task automatic set_req(input int i, input int v, input int code, input int len);
        REQ_VALID[i]            = v[0];
        REQ_CODE[i*CODE_W +: CODE_W] = code[CODE_W-1:0];
        REQ_LEN[i*2 +: 2]       = len[1:0];
    endtask

    // Expected per-cycle outputs as a list of slots: each pixel held DWELL
    // cycles, then one SCAN cycle repeating the last output before the next slot.
    task automatic build_trace(input int len_cycles);
        int idx, len, code, wrap, lg, gg;
        q_led.delete();
        q_gnt.delete();
        q_fd.delete();
        lg = 0;
        gg = 0;
        while (q_led.size() < len_cycles) begin
            idx = -1;
            for (int i = 1; i <= NUM_REQ; i++) begin
                if (idx < 0 && REQ_VALID[(mptr + i) % NUM_REQ])
                    idx = (mptr + i) % NUM_REQ;
            end
            if (idx < 0) begin
                q_led.push_back(0);
                q_gnt.push_back(0);
                q_fd.push_back(0);
            end else begin
                wrap = (idx <= mptr) ? 1 : 0;
                mptr = idx;
                len  = int'(REQ_LEN[idx*2 +: 2]);
                if (len == 0) len = 1;
                code = int'(REQ_CODE[idx*CODE_W +: CODE_W]);
                for (int off = 0; off < len; off++) begin
                    for (int d = 0; d < DWELL; d++) begin
                        lg = pix(code, off);
                        gg = 1 << idx;
                        q_led.push_back(lg);
                        q_gnt.push_back(gg);
                        q_fd.push_back((wrap == 1 && off == 0 && d == 0) ? 1 : 0);
                    end
                end
                q_led.push_back(lg);
                q_gnt.push_back(gg);
                q_fd.push_back(0);
            end
        end
    endtask

    task automatic run_episode(input string tag, input int len_cycles);
        EN = 1'b0;
        step();
        step();
        check_out({tag, ".idle"}, 0, 0, 0);
        build_trace(len_cycles);
        EN = 1'b1;
        step();
        check_out({tag, ".scan"}, 0, 0, 0);
        for (int k = 0; k < len_cycles; k++) begin
            step();
            check_out($sformatf("%s.c%0d", tag, k), q_led[k], q_gnt[k], q_fd[k]);
        end
        EN = 1'b0;
        step();
        check_out({tag, ".off"}, 0, 0, 0);
    endtask

    initial begin
        RSTn      = 1'b0;
        EN        = 1'b0;
        REQ_VALID = '0;
        REQ_CODE  = '0;
        REQ_LEN   = '0;
        mptr      = NUM_REQ - 1;
        step();
        check_out("reset", 0, 0, 0);
        RSTn = 1'b1;
        step();

        // Two requesters, runs of 3 and 1
        set_req(0, 1, 'h268, 3);
        set_req(2, 1, 'h210, 1);
        run_episode("two_req", 40);

        // Column overflow on the third sub-slot
        REQ_VALID = '0;
        set_req(0, 1, 'h26E, 3);
        run_episode("col_ovf", 30);

        // Nothing valid, then a late requester
        REQ_VALID = '0;
        EN = 1'b1;
        for (int k = 0; k < 10; k++) begin
            step();
            check_out($sformatf("none.c%0d", k), 0, 0, 0);
        end
        set_req(3, 1, 'h123, 1);
        step();
        step();
        check("late.grant", int'(GRANT), 'b1000);
        check("late.led", int'(LEDout), 'h123);
        mptr = 3;
        EN = 1'b0;
        step();

        // Abort when the granted requester drops mid-dwell
        REQ_VALID = '0;
        set_req(0, 1, 'h100, 2);
        set_req(2, 1, 'h0A1, 2);
        EN = 1'b1;
        step();
        step();
        check("abort.pick", int'(GRANT), 'b0001);
        step();
        REQ_VALID[0] = 1'b0;
        step();
        check("abort.hold_g", int'(GRANT), 'b0001);
        check("abort.hold_l", int'(LEDout), 'h100);
        step();
        check("abort.next_g", int'(GRANT), 'b0100);
        check("abort.next_l", int'(LEDout), 'h0A1);

        // Asynchronous reset between edges
        #3;
        RSTn = 1'b0;
        #1;
        check_out("async_rst", 0, 0, 0);
        EN = 1'b0;
        step();
        RSTn = 1'b1;
        mptr = NUM_REQ - 1;
        REQ_VALID = '0;
        for (int i = 0; i < NUM_REQ; i++) set_req(i, 1, 'h040 + i * 'h41, 1);
        run_episode("post_rst", 24);

        for (int e = 0; e < 30; e++) begin
            for (int i = 0; i < NUM_REQ; i++)
                set_req(i, int'($urandom_range(0, 1)), int'($urandom_range(0, 1023)),
                        int'($urandom_range(0, 3)));
            run_episode($sformatf("rnd%0d", e), int'($urandom_range(10, 70)));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/led_slot_scheduler.md
Name: led_slot_scheduler

Overview:
- Time-division scheduler that shares the single 10-bit LEDout drive word of the dot-matrix display between several sprite requesters (paddles, ball, score markers).
- Each requester presents a base pixel code and a run length of 1–3 consecutive pixels.
- The block grants requesters round-robin, drives each pixel for a fixed dwell, and skips idle requesters.
- It replaces ad-hoc color-counter case decoding in the game top level.

Parameters:
- NUM_REQ, 4, number of requesters (2..8)
- DWELL, 2001, clocks each pixel is held on LEDout (≥2)
- CODE_W, 10, width of the LED drive code

Ports:
- CLK  in  1  system clock
- RSTn  in  1  reset; asynchronous, active-low
- EN  in  1  scheduler enable
- REQ_VALID  in  NUM_REQ  per-requester "sprite visible"
- REQ_CODE  in  NUM_REQ*CODE_W  base code per requester; bits [2:0] = x column
- REQ_LEN  in  NUM_REQ*2  pixel run length; 0 treated as 1
- LEDout  out  CODE_W  registered drive code; 0 = blank
- GRANT  out  NUM_REQ  one-hot requester currently driven; 0 when none
- FRAME_DONE  out  1  one-cycle pulse on round-robin wrap

Behaviour:
- Reset: state IDLE, LEDout=0, GRANT=0, FRAME_DONE=0, ptr=NUM_REQ-1, dwell=0, offset=0.
- States:
  - IDLE: outputs 0. EN=1 → SCAN next cycle.
  - SCAN: one cycle. Picks the first requester with REQ_VALID=1, searching circularly from ptr+1. If found:
    - latch its code and length
    - ptr ← index, offset ← 0, dwell ← 0
    - GRANT ← onehot(index); LEDout ← pixel code
    - → DRIVE
    - FRAME_DONE=1 in that same update if index ≤ old ptr (wrap; with a single valid requester, every pick wraps).
  - SCAN with no valid requester: LEDout=0, GRANT=0, stay in SCAN and re-evaluate every cycle.
  - DRIVE: dwell counts 0..DWELL-1. At DWELL-1:
    - if offset < len-1: offset++, dwell ← 0, LEDout updated on the same edge
    - else → SCAN, with LEDout/GRANT held through the SCAN cycle until the new pick loads.
- Pixel code = latched_code + offset (CODE_W-bit add). If latched_code[2:0]+offset > 7, that sub-slot outputs 0 for its full dwell: no carry into the row bits, no wrap to column 0.
- Latched values are used for the whole slot; changes to REQ_CODE/REQ_LEN during DRIVE have no effect until the next grant.
- REQ_VALID of the granted requester falls during DRIVE → abort; next cycle is SCAN, and outputs keep their last value until the pick.
- EN=0 in any state → IDLE on the next edge; LEDout=0, GRANT=0; ptr retained, so resume continues round-robin.
- Timing: EN rises at edge t → SCAN at t+1 → LEDout/GRANT valid after edge t+2. One pixel period = DWELL clocks; each requester change costs 1 extra SCAN cycle.
- All outputs are registered; there are no combinational paths from inputs to outputs.

Optional Feature:
- Macro LED_SCHED_BLANK_EN.
- Defined: adds state BLANK between DRIVE end and SCAN. LEDout=0, GRANT=0 for exactly DWELL clocks (anti-ghosting); EN=0 still exits to IDLE immediately.
- Undefined: DRIVE → SCAN directly as above; no BLANK state is synthesized.

Decomposition:
- Package led_sched_pkg:
  - state enum {IDLE, SCAN, DRIVE, BLANK}
  - CODE_W default
  - BLANK_CODE = 0
  - X_MSB = 2 (column field bound)
  - MAX_LEN = 3
- Sub-module led_rr_pick: combinational circular priority finder (inputs valid vector, ptr; outputs found, index), reused by future arbiters.

Test Plan:
- DWELL=4, NUM_REQ=4, EN=1, valid=4'b0101, codes 0x268/0x210, len 3/1 → LEDout sequence 0x268, 0x269, 0x26A (4 clk each), then 0x210 (4 clk); FRAME_DONE pulses when req0 is re-picked.
- Code 0x26E, len 3 → 0x26E, 0x26F, then 0x000 for the third sub-slot; GRANT stays 4'b0001 throughout.
- valid=0, EN=1 → LEDout=0, GRANT=0 indefinitely. Setting valid[3]=1 → GRANT=4'b1000 two edges later.
- Drop valid[0] at dwell=1 of its slot → abort: next requester granted within 2 clocks, no full dwell spent.
- Assert RSTn=0 mid-DRIVE (asynchronous, between edges) → LEDout, GRANT and FRAME_DONE go 0 immediately. After release, the first pick is req0.
- With LED_SCHED_BLANK_EN: two valid requesters → DWELL clocks of LEDout=0, GRANT=0 between their slots. EN=0 during BLANK → IDLE on the next edge.
